// File: rtl/pe_mac_seq.sv
// Sequencer and partial-sum holder for the PE multiply-accumulate datapath.
// Streams operand pairs into the datapath, optionally folds one external psum, and returns the sum.
module pe_mac_seq #(
    parameter int SIZEIN  = 16,
    parameter int SIZEOUT = 40,
    parameter int LENW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LENW-1:0]    cfg_len,
    input  logic               cfg_ext,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIZEIN-1:0]  in_a,
    input  logic [SIZEIN-1:0]  in_b,
    input  logic               psum_in_valid,
    output logic               psum_in_ready,
    input  logic [SIZEIN-1:0]  psum_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZEOUT-1:0] out_psum,
    output logic [SIZEIN-1:0]  mac_a,
    output logic [SIZEIN-1:0]  mac_b,
    output logic               mac_gate,
    output logic               mac_clear,
    output logic               mac_exter,
    output logic [SIZEIN-1:0]  mac_ext_psum,
    output logic [SIZEOUT-1:0] mac_int_psum,
    input  logic [SIZEOUT-1:0] mac_accum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_EXT,
        S_EXT_FOLD,
        S_OUT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LENW-1:0]     r_len;
    logic [LENW-1:0]     r_cnt;
    logic                r_ext;
    logic                r_clr_pend;
    logic [SIZEOUT-1:0]  r_acc;
    logic                w_beat;
    logic                w_acc_load;

    // Readiness in MAC depends only on state, so the beat can be decoded without feedback.
    assign w_beat       = in_valid && (r_state == S_MAC);
    assign mac_a        = w_beat ? in_a : '0;
    assign mac_b        = w_beat ? in_b : '0;
    assign mac_ext_psum = psum_in;
    assign mac_int_psum = r_acc;
    assign out_psum     = r_acc;
    assign busy         = (r_state != S_IDLE);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        psum_in_ready = 1'b0;
        out_valid     = 1'b0;
        mac_gate      = 1'b1;
        mac_clear     = 1'b1;
        mac_exter     = 1'b0;
        w_acc_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_MAC;
            end
            S_MAC: begin
                in_ready   = 1'b1;
                mac_gate   = !w_beat;
                mac_clear  = r_clr_pend;
                w_acc_load = 1'b1;
                if (w_beat && (r_cnt == r_len - LENW'(1))) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                mac_clear   = r_clr_pend;
                w_acc_load  = 1'b1;
                w_state_nxt = r_ext ? S_EXT : S_OUT;
            end
            S_EXT: begin
                psum_in_ready = 1'b1;
                mac_clear     = 1'b0;
                if (psum_in_valid) begin
                    mac_exter   = 1'b1;
                    w_state_nxt = S_EXT_FOLD;
                end
            end
            S_EXT_FOLD: begin
                mac_clear   = 1'b0;
                w_acc_load  = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_ext      <= 1'b0;
            r_clr_pend <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_len      <= (cfg_len == '0) ? LENW'(1) : cfg_len;
                r_ext      <= cfg_ext;
                r_cnt      <= '0;
                r_clr_pend <= 1'b1;
            end else begin
                if (w_beat) r_cnt <= r_cnt + LENW'(1);
                // The first product reaches the adder one cycle after its beat; keep clearing until then.
                if (r_cnt != '0) r_clr_pend <= 1'b0;
            end
            if (w_acc_load) r_acc <= mac_accum;
        end
    end

endmodule

// File: tb/tb_pe_mac_seq.sv
// Self-checking bench for pe_mac_seq: models the MAC datapath around it and compares
// each job's result and latency against sums computed directly from the operand lists.
module tb_pe_mac_seq;

    localparam int SIZEIN  = 16;
    localparam int SIZEOUT = 40;
    localparam int LENW    = 8;
    localparam int MAX_CYC = 300;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [LENW-1:0]    cfg_len;
    logic               cfg_ext;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [SIZEIN-1:0]  in_a;
    logic [SIZEIN-1:0]  in_b;
    logic               psum_in_valid;
    logic               psum_in_ready;
    logic [SIZEIN-1:0]  psum_in;
    logic               out_valid;
    logic               out_ready;
    logic [SIZEOUT-1:0] out_psum;
    logic [SIZEIN-1:0]  mac_a;
    logic [SIZEIN-1:0]  mac_b;
    logic               mac_gate;
    logic               mac_clear;
    logic               mac_exter;
    logic [SIZEIN-1:0]  mac_ext_psum;
    logic [SIZEOUT-1:0] mac_int_psum;
    logic [SIZEOUT-1:0] mac_accum;

    int errors = 0;
    int checks = 0;

    pe_mac_seq #(.SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .LENW(LENW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_ext(cfg_ext),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .mac_a(mac_a), .mac_b(mac_b), .mac_gate(mac_gate), .mac_clear(mac_clear),
        .mac_exter(mac_exter), .mac_ext_psum(mac_ext_psum), .mac_int_psum(mac_int_psum),
        .mac_accum(mac_accum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: adder input register plus combinational adder.
    logic signed [2*SIZEIN-1:0] dp_prod;
    logic        [SIZEOUT-1:0]  dp_pinb;
    assign dp_prod   = $signed(mac_a) * $signed(mac_b);
    assign mac_accum = (mac_clear ? '0 : mac_int_psum) + dp_pinb;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         dp_pinb <= '0;
        else if (mac_exter) dp_pinb <= {{(SIZEOUT-SIZEIN){mac_ext_psum[SIZEIN-1]}}, mac_ext_psum};
        else if (mac_gate)  dp_pinb <= '0;
        else                dp_pinb <= {{(SIZEOUT-2*SIZEIN){dp_prod[2*SIZEIN-1]}}, dp_prod};
    end

    // Job description and results.
    int                 j_len_cfg;
    bit                 j_ext;
    shortint            j_a[$];
    shortint            j_b[$];
    shortint            j_psum;
    int                 j_gap;
    bit                 j_rand_gap;
    int                 j_psum_delay;
    int                 j_hold;
    int                 j_abort_beats;
    logic [SIZEOUT-1:0] res_psum;
    int                 res_cyc;

    function automatic logic [SIZEOUT-1:0] ref_sum();
        longint s = 0;
        foreach (j_a[i]) s += longint'(j_a[i]) * longint'(j_b[i]);
        if (j_ext) s += longint'(j_psum);
        return s[SIZEOUT-1:0];
    endfunction

    task automatic job_defaults();
        j_a.delete();
        j_b.delete();
        j_ext = 0; j_psum = 0; j_gap = 0; j_rand_gap = 0;
        j_psum_delay = 0; j_hold = 0; j_abort_beats = 0;
    endtask

    // Runs one job from start to result handshake; called at 1 time unit after a rising edge.
    task automatic run_job(input string name);
        int idx = 0, gap_left = 0, ext_wait = 0, cyc = 0, bubbles = 0, eff_len, exp_cyc;
        bit beat, prev_beat = 0, quiet_ext, quiet_mac;
        logic [SIZEOUT-1:0] acc_before, exp_psum;
        eff_len = j_a.size();
        exp_psum = ref_sum();
        start = 1'b1; cfg_len = LENW'(j_len_cfg); cfg_ext = j_ext; psum_in = j_psum;
        in_valid = 1'b0; psum_in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; cfg_len = LENW'($urandom); cfg_ext = 1'($urandom);
        cyc = 1;
        while (!out_valid && cyc < MAX_CYC) begin
            in_valid = (idx < eff_len) && (gap_left == 0);
            if (in_valid) begin
                in_a = j_a[idx];
                in_b = j_b[idx];
            end else begin
                in_a = SIZEIN'($urandom);
                in_b = SIZEIN'($urandom);
            end
            psum_in_valid = j_ext && (ext_wait >= j_psum_delay);
            #1;
            beat = in_valid && in_ready;
            checks++;
            if ({mac_a, mac_b, mac_gate} !== (beat ? {in_a, in_b, 1'b0} : {{(2*SIZEIN){1'b0}}, 1'b1})) begin
                errors++;
                $display("FAIL %s mac_ops cyc=%0d: got a=%h b=%h gate=%b, want beat=%b a=%h b=%h",
                         name, cyc, mac_a, mac_b, mac_gate, beat, in_a, in_b);
            end
            checks++;
            if (in_ready && psum_in_ready) begin
                errors++;
                $display("FAIL %s ready_overlap cyc=%0d: in_ready and psum_in_ready both 1", name, cyc);
            end
            if (in_ready && !in_valid) bubbles++;
            quiet_ext  = psum_in_ready && !psum_in_valid;
            quiet_mac  = in_ready && !in_valid && !prev_beat && idx > 0;
            acc_before = mac_int_psum;
            @(posedge clk); #1;
            cyc++;
            prev_beat = beat;
            if (beat) begin
                idx++;
                gap_left = j_rand_gap ? int'($urandom_range(0, 2)) : j_gap;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            if (quiet_ext) ext_wait++;
            if (quiet_ext || quiet_mac) begin
                checks++;
                if (mac_int_psum !== acc_before) begin
                    errors++;
                    $display("FAIL %s acc_hold cyc=%0d: got %h, want %h", name, cyc, mac_int_psum, acc_before);
                end
            end
            if (j_abort_beats > 0 && idx >= j_abort_beats) return;
        end
        res_cyc  = cyc;
        res_psum = out_psum;
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s timeout: no out_valid within %0d cycles", name, MAX_CYC);
            rst_n = 1'b0; #1; rst_n = 1'b1;
            return;
        end
        exp_cyc = eff_len + 2 + bubbles + (j_ext ? 2 + ext_wait : 0);
        checks++;
        if (res_psum !== exp_psum || res_cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s result: got psum=%0d cyc=%0d, want psum=%0d cyc=%0d",
                     name, $signed(res_psum), res_cyc, $signed(exp_psum), exp_cyc);
        end
        in_valid = 1'b0; psum_in_valid = 1'b0;
        for (int k = 0; k < j_hold; k++) begin
            start = 1'b1; cfg_len = 8'd7;
            @(posedge clk); #1;
            checks++;
            if (!out_valid || out_psum !== exp_psum || !busy) begin
                errors++;
                $display("FAIL %s out_hold k=%0d: got valid=%b busy=%b psum=%0d, want 1 1 %0d",
                         name, k, out_valid, busy, $signed(out_psum), $signed(exp_psum));
            end
        end
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid || busy) begin
            errors++;
            $display("FAIL %s after_handshake: got valid=%b busy=%b, want 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_ext = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; psum_in_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
        #3;
        checks++;
        if ({out_valid, in_ready, psum_in_ready, busy, mac_gate, mac_clear, mac_exter} !== 7'b0000110) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 0000110",
                     {out_valid, in_ready, psum_in_ready, busy, mac_gate, mac_clear, mac_exter});
        end
        checks++;
        if ({out_psum, mac_int_psum, mac_a, mac_b} !== '0) begin
            errors++;
            $display("FAIL reset_data: got psum=%h int=%h a=%h b=%h, want 0", out_psum, mac_int_psum, mac_a, mac_b);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_basic_beats();
        job_defaults();
        j_len_cfg = 3;
        j_a = '{2, -4, 7};
        j_b = '{3, 5, 7};
    endtask

    task automatic test_basic();
        load_basic_beats();
        run_job("basic");
        checks++;
        if (res_psum !== 40'sd35 || res_cyc != 5) begin
            errors++;
            $display("FAIL basic_spec: got psum=%0d cyc=%0d, want 35 5", $signed(res_psum), res_cyc);
        end
    endtask

    task automatic test_ext();
        load_basic_beats();
        j_ext = 1; j_psum = -100;
        run_job("ext");
        checks++;
        if (res_psum !== -40'sd65 || res_cyc != 7) begin
            errors++;
            $display("FAIL ext_spec: got psum=%0d cyc=%0d, want -65 7", $signed(res_psum), res_cyc);
        end
    endtask

    task automatic test_stall();
        load_basic_beats();
        j_ext = 1; j_psum = -100; j_gap = 2; j_psum_delay = 3;
        run_job("stall");
        checks++;
        if (res_psum !== -40'sd65 || res_cyc != 14) begin
            errors++;
            $display("FAIL stall_spec: got psum=%0d cyc=%0d, want -65 14", $signed(res_psum), res_cyc);
        end
    endtask

    task automatic test_len0_hold();
        job_defaults();
        j_len_cfg = 0; j_a = '{-32768}; j_b = '{-32768}; j_hold = 5;
        run_job("len0_hold");
        checks++;
        if (res_psum !== 40'sd1073741824 || res_cyc != 3) begin
            errors++;
            $display("FAIL len0_spec: got psum=%0d cyc=%0d, want 1073741824 3", $signed(res_psum), res_cyc);
        end
    endtask

    task automatic test_back_to_back();
        job_defaults();
        j_len_cfg = 3; j_a = '{100, 100, 100}; j_b = '{100, 100, 100};
        run_job("b2b_job1");
        checks++;
        if (res_psum !== 40'sd30000) begin
            errors++;
            $display("FAIL b2b_job1_spec: got %0d, want 30000", $signed(res_psum));
        end
        job_defaults();
        j_len_cfg = 1; j_a = '{1}; j_b = '{-1};
        run_job("b2b_job2");
        checks++;
        if (res_psum !== -40'sd1) begin
            errors++;
            $display("FAIL b2b_job2_spec: got %0d, want -1", $signed(res_psum));
        end
    endtask

    task automatic test_reset_mid();
        job_defaults();
        j_len_cfg = 3; j_a = '{5, 6, 7}; j_b = '{5, 6, 7}; j_abort_beats = 2;
        run_job("reset_mid_abort");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, psum_in_ready, busy, mac_gate, mac_clear, mac_exter} !== 7'b0000110) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got %b, want 0000110",
                     {out_valid, in_ready, psum_in_ready, busy, mac_gate, mac_clear, mac_exter});
        end
        checks++;
        if ({out_psum, mac_int_psum, mac_a, mac_b} !== '0) begin
            errors++;
            $display("FAIL reset_mid_data: got psum=%h int=%h a=%h b=%h, want 0", out_psum, mac_int_psum, mac_a, mac_b);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        job_defaults();
        j_len_cfg = 3; j_a = '{1, 1, 1}; j_b = '{1, 1, 1};
        run_job("reset_mid_fresh");
        checks++;
        if (res_psum !== 40'sd3) begin
            errors++;
            $display("FAIL reset_mid_fresh_spec: got %0d, want 3", $signed(res_psum));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int eff;
            job_defaults();
            j_len_cfg = $urandom_range(0, 6);
            eff = (j_len_cfg == 0) ? 1 : j_len_cfg;
            for (int i = 0; i < eff; i++) begin
                j_a.push_back(shortint'($urandom));
                j_b.push_back(shortint'($urandom));
            end
            j_ext        = 1'($urandom);
            j_psum       = shortint'($urandom);
            j_rand_gap   = 1;
            j_psum_delay = $urandom_range(0, 3);
            j_hold       = $urandom_range(0, 2);
            run_job("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ext();
        test_stall();
        test_len0_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_mac_seq.md
# pe_mac_seq

Sequencer and partial-sum holder that sits directly upstream of the PE multiply-accumulate datapath. It accepts a stream of operand pairs over valid/ready and drives the datapath's gate/clear/external-select controls. It owns the partial-sum register fed back as the datapath's internal psum, optionally folds in one external psum from a neighbouring PE, and delivers the finished 40-bit sum over valid/ready.

## Interface
- SIZEIN, 16, operand and external-psum width
- SIZEOUT, 40, partial-sum width
- LENW, 8, width of the products-per-output count
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  job start pulse, honoured only in IDLE
- cfg_len  in  LENW  products per output, sampled on start; 0 treated as 1
- cfg_ext  in  1  add one external psum after the products, sampled on start
- busy  out  1  high in every state except IDLE
- in_valid / in_ready  in / out  1  operand handshake
- in_a, in_b  in  SIZEIN  signed operands
- psum_in_valid / psum_in_ready  in / out  1  external psum handshake
- psum_in  in  SIZEIN  signed external psum
- out_valid / out_ready  out / in  1  result handshake
- out_psum  out  SIZEOUT  signed result, equals the psum register
- mac_a, mac_b  out  SIZEIN  operands to datapath; in_a/in_b on an accepted beat, else 0
- mac_gate  out  1  high forces the product to 0
- mac_clear  out  1  high selects 0 instead of the internal psum
- mac_exter  out  1  high selects the external psum into the adder input register
- mac_ext_psum  out  SIZEIN  psum_in passthrough
- mac_int_psum  out  SIZEOUT  psum register (acc_q)
- mac_accum  in  SIZEOUT  datapath adder output

## Operation
- Datapath contract:
  - Adder input register PinB loads at each edge: external psum if mac_exter, else product (0 if mac_gate).
  - mac_accum = (mac_clear ? 0 : acc_q) + PinB, combinationally.
  - A beat accepted in cycle t therefore appears in mac_accum during cycle t+1.
- FSM states: IDLE, MAC, DRAIN, EXT, EXT_FOLD, OUT.
- IDLE:
  - in_ready=0, mac_gate=1, mac_clear=1.
  - On start: latch len=max(cfg_len,1) and ext=cfg_ext, zero cnt, set clr_pend=1, go to MAC.
- MAC:
  - in_ready=1, mac_gate=!(in_valid&&in_ready), mac_exter=0, mac_clear=clr_pend.
  - acc_q <= mac_accum every cycle.
  - On an accepted beat, cnt++. clr_pend clears at the end of the cycle after the first accepted beat.
  - Bubbles add 0 because PinB=0.
  - The accepted beat with cnt==len-1 moves to DRAIN.
- DRAIN:
  - in_ready=0, mac_gate=1, mac_clear=clr_pend, acc_q <= mac_accum. This folds the last product.
  - Next state: EXT if ext, else OUT.
- EXT:
  - psum_in_ready=1. While psum_in_valid=0: mac_exter=0, mac_gate=1, acc_q holds.
  - On handshake: mac_exter=1, go to EXT_FOLD.
- EXT_FOLD: mac_exter=0, mac_gate=1, mac_clear=0, acc_q <= mac_accum, go to OUT.
- OUT:
  - out_valid=1, out_psum=acc_q held stable, mac_gate=1.
  - On out_ready go to IDLE.
- Arithmetic: two's complement, acc_q wraps modulo 2^SIZEOUT, external psum sign-extended by the datapath.
- start outside IDLE is ignored.
- in_ready is never high outside MAC, and psum_in_ready never high outside EXT.

## Timing
- Reset values:
  - state=IDLE, acc_q=0, out_psum=0, mac_int_psum=0.
  - out_valid=0, in_ready=0, psum_in_ready=0, busy=0.
  - mac_gate=1, mac_clear=1, mac_exter=0, mac_a=mac_b=0.
- Reset asserted mid-job: all of the above take effect immediately. The job is lost and no out_valid is produced.
- Latency with start in cycle 0 and back-to-back beats:
  - beats accepted in cycles 1..L, DRAIN at L+1, out_valid at L+2.
  - with ext and psum_in_valid already high: EXT L+2, EXT_FOLD L+3, out_valid L+4.
- Each in_valid-low cycle during MAC adds one cycle. Each psum_in_valid-low cycle in EXT adds one cycle.
- Handshakes are standard: transfer when valid&&ready in the same cycle.
- out_valid stays high and out_psum stays stable until out_ready.
- Throughput: one result per L+3 cycles minimum (L+5 with ext), including one IDLE cycle.

## Test plan
- len=3, ext=0, beats (2,3),(-4,5),(7,7) back-to-back -> out_psum=35, out_valid in cycle 5.
- Same beats, ext=1, psum_in=-100 valid throughout -> out_psum=-65, out_valid in cycle 7.
- Same beats with in_valid low for 2 cycles between each beat and psum_in_valid delayed 3 cycles -> out_psum=-65, acc_q unchanged during waits.
- cfg_len=0, beat (-32768,-32768) -> out_psum=1073741824. Then hold out_ready=0 for 5 cycles -> out_valid and out_psum stable; start pulses during that time are ignored.
- Two jobs back-to-back: job 1 = 3 beats of (100,100); job 2 = 1 beat of (1,-1) -> results 30000 then -1, proving clear of the previous psum.
- rst_n pulsed low after 2 beats of a len=3 job -> all outputs at reset values immediately. A fresh job (1,1)x3 -> out_psum=3.
